// File: rtl/alu_seq.sv
// Multi-byte operation sequencer driving an 8-bit combinational ALU one byte per pass,
// with local carry/shift fix-up passes chained between bytes.
module alu_seq #(
   parameter int NBYTES = 2,
   localparam int W = 8 * NBYTES
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [2:0]   i_op,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [7:0]   o_alu_l,
   output logic [7:0]   o_alu_r,
   output logic [2:0]   o_alu_op,
   input  logic [7:0]   i_alu,
   input  logic [2:0]   i_alu_flags,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_result,
   output logic         o_carry,
   output logic         o_zero,
   output logic         o_neg
);

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_ADC = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LSL = 3'd5;
   localparam logic [2:0] OP_LSR = 3'd6;
   localparam logic [2:0] OP_NOP = 3'd7;

   typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

   state_t                 state, state_next;
   logic [2:0]             op;
   logic [NBYTES-1:0][7:0] a, b, result;
   logic                   carry_prev, c1_hold;
   logic [IW-1:0]          idx, idx_next;
   logic                   is_arith, is_logic, is_shift;
   logic                   need_fix, last_byte, pass_carry;
   logic                   flags_unused;

   // Only the carry flag matters; zero/neg are recomputed over the full width.
   assign flags_unused = i_alu_flags[2] ^ i_alu_flags[0];

   assign is_arith   = (op == OP_ADD) || (op == OP_ADC);
   assign is_logic   = (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
   assign is_shift   = (op == OP_LSL) || (op == OP_LSR);
   assign need_fix   = carry_prev & (is_arith | is_shift);
   assign pass_carry = (is_arith | is_shift) & i_alu_flags[1];
   assign last_byte  = (op == OP_LSR) ? (idx == '0) : (idx == IW'(NBYTES - 1));
   assign idx_next   = (op == OP_LSR) ? (idx - 1'b1) : (idx + 1'b1);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      o_alu_l    = 8'h00;
      o_alu_r    = 8'h00;
      o_alu_op   = 3'd0;
      case (state)
         IDLE: begin
            if (i_valid) begin
               state_next = (i_op == OP_NOP) ? DONE : PASS1;
            end
         end
         PASS1: begin
            o_alu_l  = a[idx];
            o_alu_r  = is_shift ? 8'h01 : b[idx];
            o_alu_op = is_arith ? OP_ADD : op;
            if (need_fix) begin
               state_next = PASS2;
            end else if (last_byte) begin
               state_next = DONE;
            end else begin
               state_next = PASS1;
            end
         end
         PASS2: begin
            // Inject the incoming carry/shift bit into the byte just produced.
            o_alu_l    = result[idx];
            o_alu_r    = (op == OP_LSR) ? 8'h80 : 8'h01;
            o_alu_op   = is_arith ? OP_ADD : OP_OR;
            state_next = last_byte ? DONE : PASS1;
         end
         DONE: begin
            if (i_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         op         <= OP_NOP;
         a          <= '0;
         b          <= '0;
         result     <= '0;
         carry_prev <= 1'b0;
         c1_hold    <= 1'b0;
         idx        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  op         <= i_op;
                  a          <= i_a;
                  b          <= i_b;
                  result     <= '0;
                  carry_prev <= (i_op == OP_ADC) ? i_cin : 1'b0;
                  c1_hold    <= 1'b0;
                  idx        <= (i_op == OP_LSR) ? IW'(NBYTES - 1) : '0;
               end
            end
            PASS1: begin
               result[idx] <= i_alu;
               if (need_fix) begin
                  c1_hold <= pass_carry;
               end else begin
                  carry_prev <= pass_carry;
                  if (!last_byte) begin
                     idx <= idx_next;
                  end
               end
            end
            PASS2: begin
               // An add fix-up can itself carry out; the shift OR-in cannot.
               result[idx] <= i_alu;
               carry_prev  <= is_arith ? (c1_hold | i_alu_flags[1]) : c1_hold;
               if (!last_byte) begin
                  idx <= idx_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ready  = (state == IDLE);
   assign o_valid  = (state == DONE);
   assign o_result = result;
   assign o_carry  = (state == DONE) & ~is_logic & (is_arith | is_shift) & carry_prev;
   assign o_zero   = ~|result;
   assign o_neg    = result[NBYTES-1][7];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural 8-bit ALU attached to the ALU port,
// directed plan scenarios plus randomized commands against a full-width arithmetic model.
module tb_alu_seq;

   localparam int NB = 2;
   localparam int W  = 8 * NB;

   logic         i_clk = 1'b0;
   logic         i_reset = 1'b1;
   logic         i_valid = 1'b0;
   logic         i_ready = 1'b0;
   logic         i_cin = 1'b0;
   logic [2:0]   i_op = 3'd0;
   logic [W-1:0] i_a = '0;
   logic [W-1:0] i_b = '0;
   logic         o_ready, o_valid, o_carry, o_zero, o_neg;
   logic [W-1:0] o_result;
   logic [7:0]   o_alu_l, o_alu_r, i_alu;
   logic [2:0]   o_alu_op, i_alu_flags;

   int total = 0;
   int bad   = 0;

   logic [2:0] tr_op [40];
   logic [7:0] tr_l  [40];
   logic [7:0] tr_r  [40];
   int         tr_n;

   alu_seq #(.NBYTES(NB)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_cin(i_cin),
      .o_alu_l(o_alu_l), .o_alu_r(o_alu_r), .o_alu_op(o_alu_op),
      .i_alu(i_alu), .i_alu_flags(i_alu_flags),
      .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
      .o_carry(o_carry), .o_zero(o_zero), .o_neg(o_neg)
   );

   always #5 i_clk = ~i_clk;

   // Combinational 8-bit ALU; flags = {neg, carry, zero}.
   logic [8:0] alu_sum;
   logic       alu_c;
   always_comb begin
      alu_sum = {1'b0, o_alu_l} + {1'b0, o_alu_r};
      i_alu   = 8'h00;
      alu_c   = 1'b0;
      case (o_alu_op)
         3'd0, 3'd1: begin i_alu = alu_sum[7:0]; alu_c = alu_sum[8]; end
         3'd2: i_alu = o_alu_l & o_alu_r;
         3'd3: i_alu = o_alu_l | o_alu_r;
         3'd4: i_alu = o_alu_l ^ o_alu_r;
         3'd5: begin i_alu = {o_alu_l[6:0], 1'b0}; alu_c = o_alu_l[7]; end
         3'd6: begin i_alu = {1'b0, o_alu_l[7:1]}; alu_c = o_alu_l[0]; end
         default: ;
      endcase
      i_alu_flags = {i_alu[7], alu_c, (i_alu == 8'h00)};
   end

   // Full-width reference: result/carry by plain arithmetic, latency from true byte carries.
   function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, output logic [W-1:0] r, output logic c,
                                 output int lat);
      logic [W:0] s, m;
      logic       cin0, ck;
      int         fixes;
      r = '0;
      c = 1'b0;
      fixes = 0;
      cin0 = (op == 3'd1) ? cin : 1'b0;
      case (op)
         3'd0, 3'd1: begin s = {1'b0, a} + {1'b0, b} + (W+1)'(cin0); r = s[W-1:0]; c = s[W]; end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin r = a << 1; c = a[W-1]; end
         3'd6: begin r = a >> 1; c = a[0]; end
         default: ;
      endcase
      for (int k = 0; k < NB; k++) begin
         ck = 1'b0;
         if (op <= 3'd1) begin
            if (k == 0) begin
               ck = cin0;
            end else begin
               m  = ((W+1)'(1) << (8 * k)) - (W+1)'(1);
               s  = ({1'b0, a} & m) + ({1'b0, b} & m) + (W+1)'(cin0);
               ck = s[8 * k];
            end
         end else if (op == 3'd5) begin
            if (k > 0) ck = a[8 * k - 1];
         end else if (op == 3'd6) begin
            if (k < NB - 1) ck = a[8 * k + 8];
         end
         fixes += int'(ck);
      end
      lat = (op == 3'd7) ? 1 : 1 + NB + fixes;
   endfunction

   // Issue one command and wait (bounded) for o_valid; lat = -1 on timeout.
   task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, output int lat);
      i_op = op; i_a = a; i_b = b; i_cin = cin; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_a = W'($urandom);
      i_b = W'($urandom);
      i_cin = 1'($urandom);
      lat = 1;
      tr_n = 0;
      while (o_valid !== 1'b1 && lat < 40) begin
         tr_op[tr_n] = o_alu_op; tr_l[tr_n] = o_alu_l; tr_r[tr_n] = o_alu_r;
         tr_n++;
         @(posedge i_clk); #1;
         lat++;
      end
      if (o_valid !== 1'b1) lat = -1;
   endtask

   task automatic finish_cmd();
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      i_ready = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_hs ready=%b valid=%b want 1/0", o_ready, o_valid);
      end
      total++;
      if (o_result !== '0 || o_carry !== 1'b0 || o_zero !== 1'b1 || o_neg !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_out res=%h c=%b z=%b n=%b want 0000/0/1/0", o_result, o_carry, o_zero, o_neg);
      end
      total++;
      if (o_alu_l !== 8'h00 || o_alu_r !== 8'h00 || o_alu_op !== 3'd0) begin
         bad++; $display("[TB] FAIL reset_alu l=%h r=%h op=%0d want 0", o_alu_l, o_alu_r, o_alu_op);
      end
   endtask

   task automatic test_add();
      int lat;
      run_cmd(3'd0, 16'h00FF, 16'h0001, 1'b0, lat);
      total++;
      if (lat !== 4 || o_result !== 16'h0100 || o_carry !== 1'b0 || o_zero !== 1'b0 || o_neg !== 1'b0) begin
         bad++; $display("[TB] FAIL add lat=%0d res=%h c=%b z=%b n=%b want 4/0100/0/0/0", lat, o_result, o_carry, o_zero, o_neg);
      end
      finish_cmd();
      run_cmd(3'd1, 16'hFFFF, 16'h0000, 1'b1, lat);
      total++;
      if (lat !== 5 || o_result !== 16'h0000 || o_carry !== 1'b1 || o_zero !== 1'b1) begin
         bad++; $display("[TB] FAIL adc lat=%0d res=%h c=%b z=%b want 5/0000/1/1", lat, o_result, o_carry, o_zero);
      end
      total++;
      if (tr_op[0] !== 3'd0 || tr_op[1] !== 3'd0 || tr_r[1] !== 8'h01) begin
         bad++; $display("[TB] FAIL adc_alu op0=%0d op1=%0d r1=%h want 0/0/01", tr_op[0], tr_op[1], tr_r[1]);
      end
      finish_cmd();
   endtask

   task automatic test_shift();
      int lat;
      run_cmd(3'd5, 16'h80C0, 16'h1234, 1'b1, lat);
      total++;
      if (lat !== 4 || o_result !== 16'h0180 || o_carry !== 1'b1) begin
         bad++; $display("[TB] FAIL lsl lat=%0d res=%h c=%b want 4/0180/1", lat, o_result, o_carry);
      end
      total++;
      if (tr_op[2] !== 3'd3 || tr_r[2] !== 8'h01 || tr_op[0] !== 3'd5 || tr_l[0] !== 8'hC0) begin
         bad++; $display("[TB] FAIL lsl_alu op=%0d r=%h op0=%0d l0=%h want 3/01/5/c0", tr_op[2], tr_r[2], tr_op[0], tr_l[0]);
      end
      finish_cmd();
      run_cmd(3'd6, 16'h0181, 16'h5555, 1'b0, lat);
      total++;
      if (lat !== 4 || o_result !== 16'h00C0 || o_carry !== 1'b1) begin
         bad++; $display("[TB] FAIL lsr lat=%0d res=%h c=%b want 4/00c0/1", lat, o_result, o_carry);
      end
      total++;
      if (tr_l[0] !== 8'h01 || tr_l[1] !== 8'h81 || tr_op[2] !== 3'd3 || tr_r[2] !== 8'h80) begin
         bad++; $display("[TB] FAIL lsr_alu l0=%h l1=%h op2=%0d r2=%h want 01/81/3/80", tr_l[0], tr_l[1], tr_op[2], tr_r[2]);
      end
      finish_cmd();
   endtask

   task automatic test_hold();
      int lat;
      run_cmd(3'd4, 16'hA55A, 16'hFFFF, 1'b0, lat);
      total++;
      if (lat !== 3 || o_result !== 16'h5AA5 || o_carry !== 1'b0 || o_neg !== 1'b0) begin
         bad++; $display("[TB] FAIL xor lat=%0d res=%h c=%b n=%b want 3/5aa5/0/0", lat, o_result, o_carry, o_neg);
      end
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin i_valid = 1'b1; i_op = 3'd0; i_a = 16'h0001; i_b = 16'h0001; end
         @(posedge i_clk); #1;
         i_valid = 1'b0;
         total++;
         if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== 16'h5AA5) begin
            bad++; $display("[TB] FAIL hold%0d valid=%b ready=%b res=%h want 1/0/5aa5", i, o_valid, o_ready, o_result);
         end
      end
      finish_cmd();
      total++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL busy_ignore ready=%b valid=%b want 1/0", o_ready, o_valid);
      end
      run_cmd(3'd7, 16'hFFFF, 16'hFFFF, 1'b1, lat);
      total++;
      if (lat !== 1 || o_result !== 16'h0000 || o_zero !== 1'b1 || o_carry !== 1'b0) begin
         bad++; $display("[TB] FAIL nop lat=%0d res=%h z=%b c=%b want 1/0000/1/0", lat, o_result, o_zero, o_carry);
      end
      finish_cmd();
   endtask

   task automatic test_reset_abort();
      int lat;
      i_op = 3'd1; i_a = 16'hFFFF; i_b = 16'h0000; i_cin = 1'b1; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      total++;
      if (o_alu_op !== 3'd0 || o_alu_r !== 8'h01 || o_alu_l !== 8'hFF) begin
         bad++; $display("[TB] FAIL abort_pass2 op=%0d r=%h l=%h want 0/01/ff", o_alu_op, o_alu_r, o_alu_l);
      end
      i_reset = 1'b1;
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      total++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== '0 || o_carry !== 1'b0 || o_alu_l !== 8'h00) begin
         bad++; $display("[TB] FAIL abort ready=%b valid=%b res=%h c=%b l=%h want 1/0/0000/0/00", o_ready, o_valid, o_result, o_carry, o_alu_l);
      end
      run_cmd(3'd0, 16'h0001, 16'h0001, 1'b1, lat);
      total++;
      if (lat !== 3 || o_result !== 16'h0002 || o_carry !== 1'b0) begin
         bad++; $display("[TB] FAIL after_abort lat=%0d res=%h c=%b want 3/0002/0", lat, o_result, o_carry);
      end
      finish_cmd();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] er;
      logic         ec;
      int           el, lat;
      logic [2:0]   ops [3] = '{3'd0, 3'd6, 3'd2};
      for (int i = 0; i < 3; i++) begin
         total++;
         if (o_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b_ready%0d got=%b want 1", i, o_ready);
         end
         model(ops[i], 16'hF0F1, 16'h0F1F, 1'b0, er, ec, el);
         run_cmd(ops[i], 16'hF0F1, 16'h0F1F, 1'b0, lat);
         total++;
         if (lat !== el || o_result !== er || o_carry !== ec) begin
            bad++; $display("[TB] FAIL b2b%0d lat=%0d res=%h c=%b want %0d/%h/%b", i, lat, o_result, o_carry, el, er, ec);
         end
         finish_cmd();
      end
   endtask

   task automatic test_random();
      logic [2:0]   op;
      logic [W-1:0] a, b, er;
      logic         cin, ec;
      int           el, lat;
      for (int n = 0; n < 60; n++) begin
         op  = 3'($urandom_range(0, 7));
         a   = W'($urandom);
         b   = W'($urandom);
         cin = 1'($urandom);
         if ($urandom_range(0, 1) == 1) a[7:0] = 8'hFF;
         if ($urandom_range(0, 2) == 0) b[7:0] = 8'h01;
         model(op, a, b, cin, er, ec, el);
         run_cmd(op, a, b, cin, lat);
         total++;
         if (lat !== el) begin
            bad++; $display("[TB] FAIL rnd%0d_lat op=%0d got=%0d want=%0d", n, op, lat, el);
         end
         total++;
         if (o_result !== er || o_carry !== ec || o_zero !== (er == '0) || o_neg !== er[W-1]) begin
            bad++; $display("[TB] FAIL rnd%0d op=%0d a=%h b=%h cin=%b res=%h c=%b z=%b n=%b want %h/%b", n, op, a, b, cin, o_result, o_carry, o_zero, o_neg, er, ec);
         end
         repeat ($urandom_range(0, 2)) @(posedge i_clk);
         #1;
         finish_cmd();
      end
   endtask

   initial begin
      repeat (3) @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      test_reset();
      test_add();
      test_shift();
      test_hold();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
